// File: rtl/uart_pkg.sv
// Shared types and helpers for the byte-oriented UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} tx_state_t;

    localparam int DATA_BITS = 8;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear || tick) cnt_d = '0;
    end

    // NOTE: flops are written with non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and sends them LSB-first as UART frames.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fifo_empty,
    output logic        fifo_re,
    input  logic [7:0]  fifo_dout,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 tick, timer_clear, last_stop;

    // Timer only runs while bits are on the line, so every START begins at count 0.
    assign timer_clear = state_q inside {IDLE, POP, LOAD};

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick)
    );

    assign last_stop  = (state_q == STOP) && tick && (bit_idx_q == 3'(STOP_BITS - 1));
    assign fifo_re    = (state_q == IDLE) && en && !fifo_empty && !rst;
    assign busy       = (state_q != IDLE);
    assign frame_done = last_stop;
    assign frame_cnt  = frame_cnt_q;
    assign tx         = tx_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        parity_d    = parity_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE:  if (fifo_re) state_d = POP;
            POP:   state_d = LOAD;
            LOAD: begin
                shift_d   = fifo_dout;
                parity_d  = calc_parity(fifo_dout, PARITY_ODD != 0);
                bit_idx_d = '0;
                state_d   = START;
            end
            START: if (tick) state_d = DATA;
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                    bit_idx_d = '0;
                    state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            PARITY: if (tick) state_d = STOP;
            STOP: if (tick) begin
                if (last_stop) begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is derived from the next state so tx is a clean flop output.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    a_dout_known: assert property (@(posedge clk) disable iff (rst)
        (state_q == LOAD) |-> !$isunknown(fifo_dout));

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: FIFO model, byte scoreboard and line decoder.
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_re, tx, busy, frame_done;
    logic [15:0] frame_cnt;

    logic        p_empty = 1'b1;
    logic [7:0]  p_dout = 8'h07;
    logic        p_re_e, p_tx_e, p_busy_e, p_done_e;
    logic        p_re_o, p_tx_o, p_busy_o, p_done_o;
    logic [15:0] p_cnt_e, p_cnt_o;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
        .fifo_dout(fifo_dout), .tx(tx), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_even (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(p_empty), .fifo_re(p_re_e),
        .fifo_dout(p_dout), .tx(p_tx_e), .busy(p_busy_e), .frame_done(p_done_e), .frame_cnt(p_cnt_e));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(p_empty), .fifo_re(p_re_o),
        .fifo_dout(p_dout), .tx(p_tx_o), .busy(p_busy_o), .frame_done(p_done_o), .frame_cnt(p_cnt_o));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int re_cyc = -1;
    int re_count = 0;
    int re_on_empty = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int rel_cyc = 0;

    logic [7:0] fifo_mem[$];
    logic [7:0] exp_q[$];
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    // FIFO model with registered read data and write-to-flag latency of one cycle.
    always @(posedge clk) begin
        if (fifo_re === 1'b1) begin
            re_cyc = cyc;
            re_count++;
            if (fifo_empty || fifo_mem.size() == 0) re_on_empty++;
            else fifo_dout <= fifo_mem.pop_front();
        end
        if (wr_en) fifo_mem.push_back(wr_data);
        fifo_empty <= (fifo_mem.size() == 0);
        cyc = cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode 0: plain frame, 1: drop en during bit 2, 2: reset pulse during bit 4.
    task automatic rx_frame(input int mode);
        int         s;
        logic [7:0] got;
        logic [7:0] exp;
        s   = -1;
        got = 8'h00;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                s = cyc;
                break;
            end
        end
        check("start_seen", 32'(s >= 0), 32'd1);
        if (s < 0) return;
        start_cyc = s;
        check("re_to_start", s - re_cyc, 32'd3);
        for (int k = 1; k <= 39; k++) begin
            @(negedge clk);
            if (k == 2) check("start_bit", 32'(tx), 32'd0);
            if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) got = {tx, got[7:1]};
            if (k == 20) check("busy_mid", 32'(busy), 32'd1);
            if (mode == 1 && k == 14) en = 1'b0;
            if (mode == 2 && k == 22) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_tx", 32'(tx), 32'd1);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_cnt", 32'(frame_cnt), 32'd0);
                check("rst_done", 32'(frame_done), 32'd0);
                rst = 1'b0;
                rel_cyc = cyc;
                void'(exp_q.pop_front());
                return;
            end
            if (k == 38) check("stop_bit", 32'(tx), 32'd1);
            if (k == 38) check("done_early", 32'(frame_done), 32'd0);
            if (k == 39) begin
                check("frame_done", 32'(frame_done), 32'd1);
                check("done_lat", cyc - re_cyc, 32'd42);
                done_cyc = cyc;
            end
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("data", 32'(got), 32'(exp));
    endtask

    initial begin
        int base;
        int prev;
        int s;
        logic [7:0] pe;
        logic [7:0] po;

        en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cnt", 32'(frame_cnt), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);

        // Empty FIFO with en high: nothing may happen.
        base = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) base++;
        end
        check("idle_line", 32'(base), 32'd0);
        check("idle_re", 32'(re_count), 32'd0);
        check("idle_cnt", 32'(frame_cnt), 32'd0);

        // Single frame 0xA5.
        en = 1'b0;
        push_byte(8'hA5);
        en = 1'b1;
        rx_frame(0);
        @(negedge clk);
        check("a5_cnt", 32'(frame_cnt), 32'd1);
        check("a5_busy", 32'(busy), 32'd0);
        check("a5_tx", 32'(tx), 32'd1);

        // Parity variants on 0x07: even/2 stop and odd/1 stop in parallel.
        p_empty = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p_busy_e === 1'b1) break;
        end
        check("p_pop", 32'(p_busy_e), 32'd1);
        p_empty = 1'b1;
        s = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p_tx_e === 1'b0) begin
                s = cyc;
                break;
            end
        end
        check("p_start_seen", 32'(s >= 0), 32'd1);
        pe = 8'h00;
        po = 8'h00;
        for (int k = 1; k <= 47; k++) begin
            @(negedge clk);
            if (k == 2) check("p_start_o", 32'(p_tx_o), 32'd0);
            if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) begin
                pe = {p_tx_e, pe[7:1]};
                po = {p_tx_o, po[7:1]};
            end
            if (k == 38) check("par_even", 32'(p_tx_e), 32'd1);
            if (k == 38) check("par_odd", 32'(p_tx_o), 32'd0);
            if (k == 42) check("p_stop_o", 32'(p_tx_o), 32'd1);
            if (k == 43) check("p_done_o", 32'(p_done_o), 32'd1);
            if (k == 43) check("p_done_e_early", 32'(p_done_e), 32'd0);
            if (k == 46) check("p_stop2_e", 32'(p_tx_e), 32'd1);
            if (k == 46) check("p_busy2_e", 32'(p_busy_e), 32'd1);
            if (k == 47) check("p_done_e", 32'(p_done_e), 32'd1);
        end
        check("p_data_e", 32'(pe), 32'h07);
        check("p_data_o", 32'(po), 32'h07);
        @(negedge clk);
        check("p_cnt_e", 32'(p_cnt_e), 32'd1);
        check("p_cnt_o", 32'(p_cnt_o), 32'd1);

        // Burst of 16 bytes after clearing the frame counter.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("burst_clr", 32'(frame_cnt), 32'd0);
        en = 1'b0;
        base = re_count;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prev = done_cyc;
            rx_frame(0);
            if (i > 0) check("burst_gap", start_cyc - prev, 32'd4);
        end
        repeat (20) @(negedge clk);
        check("burst_cnt", 32'(frame_cnt), 32'd16);
        check("burst_re", re_count - base, 32'd16);
        check("burst_empty", 32'(fifo_empty), 32'd1);

        // en dropped mid-frame with three bytes queued.
        en = 1'b0;
        push_byte(8'h3C);
        push_byte(8'hC3);
        push_byte(8'h81);
        base = re_count;
        en = 1'b1;
        rx_frame(1);
        repeat (30) @(negedge clk);
        check("endrop_re", re_count - base, 32'd1);
        check("endrop_busy", 32'(busy), 32'd0);
        check("endrop_tx", 32'(tx), 32'd1);
        en = 1'b1;
        rx_frame(0);
        rx_frame(0);
        check("enback_re", re_count - base, 32'd3);

        // Reset during bit 4; the next byte must follow straight away.
        en = 1'b0;
        push_byte(8'h5A);
        push_byte(8'hE7);
        en = 1'b1;
        rx_frame(2);
        rx_frame(0);
        check("post_rst_pop", re_cyc, rel_cyc);
        @(negedge clk);
        check("post_rst_cnt", 32'(frame_cnt), 32'd1);
        check("sb_drained", exp_q.size(), 32'd0);
        check("re_on_empty", 32'(re_on_empty), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
